rr_arbiter: RTL

Parametrised N-way bus arbiter: successor to the fixed four-requester grant FSM, generalised to N requesters with vector ports. Selectable round-robin or fixed-priority mode, plus a hold limit that preempts a long-running grant when other requesters wait. Sits between N request sources and one shared resource, one clock domain, with registered one-hot grant outputs.

---
 rtl/rr_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin / fixed-priority arbiter with hold-limit preemption
// Grants are registered one-hot; a waiting requester forces the current owner off after MAX_HOLD cycles.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int MODE     = 1,
    parameter int MAX_HOLD = 8,
    localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id
);

    localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_gnt, w_gnt_nxt;
    logic          r_gnt_valid;
    logic [IW-1:0] r_gnt_id, w_gnt_id_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
    logic [HW-1:0] r_hold, w_hold_nxt;
    logic [N-1:0]  w_others;
    logic [IW-1:0] w_start;
    logic [IW-1:0] w_win;
    logic          w_take;

    // Increment modulo N so non-power-of-two sizes never land on an unused index.
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        return (x == LAST_IDX) ? '0 : x + 1'b1;
    endfunction

    function automatic logic [IW-1:0] pick(input logic [N-1:0] v, input logic [IW-1:0] start);
        logic [IW-1:0] idx;
        logic [IW-1:0] win;
        logic          found;
        idx   = (MODE != 0) ? start : '0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && v[idx]) begin
                win   = idx;
                found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        return win;
    endfunction

    // In IDLE r_gnt is zero, so one masked search serves both new grants and handovers.
    assign w_others = req & ~r_gnt;
    assign w_start  = (r_state == S_IDLE) ? r_ptr : wrap_inc(r_gnt_id);
    assign w_win    = pick(w_others, w_start);

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_ptr_nxt    = r_ptr;
        w_hold_nxt   = r_hold;
        w_take       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_take = 1'b1;
                end
            end
            S_GRANT: begin
                if (!req[r_gnt_id]) begin
                    if (|w_others) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_nxt  = S_IDLE;
                        w_gnt_nxt    = '0;
                        w_gnt_id_nxt = '0;
                        w_ptr_nxt    = wrap_inc(r_gnt_id);
                        w_hold_nxt   = '0;
                    end
                end else if (!(|w_others)) begin
                    if (MAX_HOLD != 0 && r_hold != HOLD_LAST) begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end else if (MAX_HOLD != 0 && r_hold == HOLD_LAST) begin
                    w_take = 1'b1;
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_take) begin
            w_state_nxt  = S_GRANT;
            w_gnt_nxt    = ONE << w_win;
            w_gnt_id_nxt = w_win;
            w_ptr_nxt    = wrap_inc(w_win);
            w_hold_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_ptr       <= '0;
            r_hold      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= |w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold      <= w_hold_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;

endmodule
